// File: rtl/prio_pkg.sv
// Shared definitions for the registered priority encoder: state encoding,
// default priority direction and a constant-foldable ceil(log2) helper.
package prio_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    localparam int LOW_FIRST_DEFAULT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_sel.sv
// Combinational priority selector: returns the winning index of vec and
// whether any bit is set; LOW_FIRST picks the direction of priority.
module prio_sel #(
    parameter int WIDTH     = 8,
    parameter int LOW_FIRST = 1,
    parameter int IDX_W     = 3
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Last match in loop order wins, so the scan runs from lowest toward
    // highest priority.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // loop can leave it unassigned and infer a latch.
        idx = '0;
        any = |vec;
        if (LOW_FIRST != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/prio_encoder_n.sv
// Registered priority encoder: requests latch into a pending vector and are
// presented one index at a time over a valid/ready handshake.
module prio_encoder_n
    import prio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LOW_FIRST = LOW_FIRST_DEFAULT,
    localparam int IDX_W    = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [IDX_W-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pending,
    output logic             coalesce
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             coalesce_q, coalesce_d;

    logic             handshake;
    logic [WIDTH-1:0] set_vec, clr_vec, sel_vec;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;

    assign handshake = out_valid_q & out_ready;
    assign set_vec   = in & {WIDTH{en}};
    assign clr_vec   = handshake ? (ONE << out_q) : '0;
    // Arrivals at this edge are excluded so the next pick only sees
    // requests that were already pending.
    assign sel_vec   = pending_q & ~clr_vec;

    prio_sel #(
        .WIDTH    (WIDTH),
        .LOW_FIRST(LOW_FIRST),
        .IDX_W    (IDX_W)
    ) u_sel (
        .vec(sel_vec),
        .idx(sel_idx),
        .any(sel_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            coalesce_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            coalesce_q  <= coalesce_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_any) state_d = PRESENT;
            PRESENT: if (handshake && !sel_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Set wins over clear for a bit requested and served at one edge.
        pending_d   = (pending_q & ~clr_vec) | set_vec;
        coalesce_d  = |(set_vec & pending_q & ~clr_vec);
        out_valid_d = (state_d == PRESENT);
        out_d       = out_q;
        if (state_d == IDLE) begin
            out_d = '0;
        end else if (state_q == IDLE || handshake) begin
            out_d = sel_idx;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign coalesce  = coalesce_q;

endmodule
